// File: rtl/div_32_pkg.sv
// Shared definitions for the multicycle signed divider: widths, FSM states
// and the INT_MIN constant used for overflow detection.
package div_32_pkg;

  localparam int unsigned WIDTH = 32;  // operand/result width (subtract_32 is fixed at 32)
  localparam int unsigned CNT_W = 6;   // iteration counter width, holds 0..WIDTH
  localparam int unsigned ITER  = 32;  // restoring-division steps per operation

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_ctrl.sv
// Divider sequencer: FSM, iteration counter and the one-cycle ready pulse.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : start/restart pulse (ctrl_DIV)
//   state        : current FSM state, decoded by the datapath
//   rdy          : registered one-cycle result-valid pulse
module div_ctrl
  import div_32_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   start,
  output state_t state,
  output logic   rdy
);

  logic [CNT_W-1:0] count;

  // A start in any state restarts from RUN and cancels a pending ready pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      rdy   <= 1'b0;
    end else if (start) begin
      state <= RUN;
      count <= '0;
      rdy   <= 1'b0;
    end else begin
      rdy <= 1'b0;
      unique case (state)
        RUN: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITER - 1)) state <= DONE;
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/subtract_32.sv
// 32-bit subtractor: out = data_a - data_b.
// Ports:
//   data_a, data_b : minuend / subtrahend
//   out            : difference (mod 2^32)
//   c32            : carry out of a + ~b + 1; 1 means no borrow (a >= b unsigned)
//   overflowCheck  : two's-complement signed overflow of the subtraction
module subtract_32 (
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic [31:0] out,
  output logic        c32,
  output logic        overflowCheck
);

  logic [32:0] sum;

  always_comb begin
    sum           = {1'b0, data_a} + {1'b0, ~data_b} + 33'd1;
    out           = sum[31:0];
    c32           = sum[32];
    overflowCheck = (data_a[31] != data_b[31]) && (sum[31] != data_a[31]);
  end

endmodule

// File: rtl/div_32.sv
// Multicycle signed 32-bit restoring divider, one quotient bit per clock.
// Quotient truncates toward zero; divide-by-zero and INT_MIN/-1 raise
// data_exception. Result is valid with a one-cycle data_resultRDY pulse
// 33 cycles after the start edge.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   data_operandA, data_operandB : dividend / divisor, sampled on ctrl_DIV
//   ctrl_DIV                     : start pulse
//   data_result                  : signed quotient, held until the next start
//   data_exception               : divide-by-zero / overflow flag
//   data_resultRDY               : one-cycle result-valid pulse
module div_32
  import div_32_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_t state;

  logic [WIDTH-1:0] neg_a, neg_b, neg_q, diff;
  logic [WIDTH-1:0] abs_a_c, abs_b_c, r_shift_c;
  logic [WIDTH-1:0] abs_b, r, q;
  logic             sign, div_zero, ovf, no_borrow;
  logic             unused_c_a, unused_v_a, unused_c_b, unused_v_b;
  logic             unused_c_q, unused_v_q, unused_v_s;

  div_ctrl u_ctrl (
    .clock (clock),
    .reset (reset),
    .start (ctrl_DIV),
    .state (state),
    .rdy   (data_resultRDY)
  );

  // Operand magnitudes: 0 - x. |INT_MIN| comes out as unsigned 2^31.
  subtract_32 u_neg_a (
    .data_a        ('0),
    .data_b        (data_operandA),
    .out           (neg_a),
    .c32           (unused_c_a),
    .overflowCheck (unused_v_a)
  );

  subtract_32 u_neg_b (
    .data_a        ('0),
    .data_b        (data_operandB),
    .out           (neg_b),
    .c32           (unused_c_b),
    .overflowCheck (unused_v_b)
  );

  // Step compare/subtract: c32=1 means the shifted remainder covers |B|.
  subtract_32 u_step (
    .data_a        (r_shift_c),
    .data_b        (abs_b),
    .out           (diff),
    .c32           (no_borrow),
    .overflowCheck (unused_v_s)
  );

  // Quotient sign correction.
  subtract_32 u_neg_q (
    .data_a        ('0),
    .data_b        (q),
    .out           (neg_q),
    .c32           (unused_c_q),
    .overflowCheck (unused_v_q)
  );

  always_comb begin
    abs_a_c   = data_operandA[WIDTH-1] ? neg_a : data_operandA;
    abs_b_c   = data_operandB[WIDTH-1] ? neg_b : data_operandB;
    // R < |B| <= 2^31, so the shifted remainder always fits in WIDTH bits.
    r_shift_c = {r[WIDTH-2:0], q[WIDTH-1]};
  end

  // Datapath: Q starts as |A| and shifts out dividend bits while shifting in quotient bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      abs_b          <= '0;
      r              <= '0;
      q              <= '0;
      sign           <= 1'b0;
      div_zero       <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      abs_b          <= abs_b_c;
      q              <= abs_a_c;
      r              <= '0;
      sign           <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero       <= (data_operandB == '0);
      ovf            <= (data_operandA == INT_MIN) && (data_operandB == '1);
      data_exception <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          r <= no_borrow ? diff : r_shift_c;
          q <= {q[WIDTH-2:0], no_borrow};
        end
        DONE: begin
          if (div_zero) begin
            data_result    <= '0;
            data_exception <= 1'b1;
          end else if (ovf) begin
            data_result    <= INT_MIN;
            data_exception <= 1'b1;
          end else begin
            data_result    <= sign ? neg_q : q;
            data_exception <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: fixed vector table, randomized operands
// against a plain-arithmetic reference, and hand-written restart/reset
// sequences.
module tb_div_32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_bad = 0;

  div_32 dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: signed division from the arithmetic rules, exception in bit 32.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'($signed(a) / $signed(b))};
  endfunction

  // Drive a one-cycle start; returns half a cycle after the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Number of rising edges after the start edge until RDY is seen (bounded).
  task automatic wait_rdy(output int n);
    n = 0;
    while (data_resultRDY !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Count RDY pulses over a window of cycles.
  task automatic count_rdy(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) seen++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input string nm);
    int n;
    start_op(a, b);
    chk({nm, " exc_clear"}, 32'(data_exception), 32'(1'b0));
    wait_rdy(n);
    chk({nm, " latency"}, 32'(n), 32'd33);
    chk({nm, " result"}, data_result, er);
    chk({nm, " exc"}, 32'(data_exception), 32'(ee));
    @(negedge clock);
    chk({nm, " rdy_fall"}, 32'(data_resultRDY), 32'(1'b0));
    chk({nm, " hold"}, data_result, er);
  endtask

  initial begin
    vec_t        vecs[10];
    logic [32:0] m;
    logic [31:0] ra, rb;
    int          n, seen;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0};
    vecs[2] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
    vecs[3] = '{32'd7,          32'd100,        32'd0,          1'b0};
    vecs[4] = '{32'd5,          32'd0,          32'd0,          1'b1};
    vecs[5] = '{32'd9,          32'd3,          32'd3,          1'b0};
    vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[7] = '{32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0};
    vecs[8] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[9] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0};

    reset = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset result", data_result, 32'd0);
    chk("reset exc", 32'(data_exception), 32'd0);
    chk("reset rdy", 32'(data_resultRDY), 32'd0);

    // Reset wins over a simultaneous start.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    reset = 1'b0;
    count_rdy(40, seen);
    chk("reset_over_start rdy", 32'(seen), 32'd0);
    chk("reset_over_start result", data_result, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, $sformatf("vec%0d", i));

    // Restart mid-run: only the second operation reports.
    start_op(32'd100, 32'd7);
    count_rdy(9, seen);
    start_op(32'd50, 32'd5);
    wait_rdy(n);
    chk("restart rdy_before", 32'(seen), 32'd0);
    chk("restart latency", 32'(n), 32'd33);
    chk("restart result", data_result, 32'd10);
    chk("restart exc", 32'(data_exception), 32'd0);

    // Reset mid-run aborts with no RDY.
    start_op(32'd100, 32'd7);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort result", data_result, 32'd0);
    chk("abort exc", 32'(data_exception), 32'd0);
    chk("abort rdy", 32'(data_resultRDY), 32'd0);
    count_rdy(40, seen);
    chk("abort no_rdy", 32'(seen), 32'd0);
    run_op(32'd81, 32'd9, 32'd9, 1'b0, "after_abort");

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = (($urandom % 6) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        3:       rb = 32'd0 - 32'($urandom_range(1, 20));
        default: rb = 32'($urandom);
      endcase
      m = model(ra, rb);
      run_op(ra, rb, m[31:0], m[32], $sformatf("rand%0d %h/%h", i, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
